bnn_feature_loader: RTL and testbench

Input stage of the microgreen BNN classifier, sitting between the top-level pins of tt_um_microgreen_bnn and the XNOR/popcount core.
- Accepts 8-bit sensor feature bytes, one per handshake.
- Binarizes each byte against a programmable threshold.
- Packs NUM_FEAT bits into a feature vector and hands it to the core over a valid/ready handshake.
- Reports buffer overrun and partial fill.

---
 rtl/bnn_feature_loader.sv | 127 ++++++++++++
 tb/tb_bnn_feature_loader.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/bnn_feature_loader.sv
// bnn_feature_loader
//   Input stage of the microgreen BNN classifier. Feature bytes arrive one per
//   strobe, get binarized against a programmable threshold, and are packed
//   into a NUM_FEAT-bit vector. The vector is offered to the XNOR/popcount
//   core over a valid/ready handshake.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       synchronous active-low reset
//   in_data     feature byte, or threshold value when in_is_thr=1
//   in_valid    single-cycle strobe qualifying in_data
//   in_is_thr   1: in_data loads the threshold; 0: in_data is a feature
//   clr         synchronous soft clear of the partial vector and overrun flag
//   feat_ready  core ready to consume the vector
//   feat_vec    binarized vector, bit i = i-th feature received
//   feat_valid  feat_vec complete and stable
//   fill_cnt    features collected into the current vector
//   thr         current threshold
//   overrun     sticky: a feature byte was dropped while a vector was held
module bnn_feature_loader #(
  parameter int          NUM_FEAT = 8,
  parameter logic [7:0]  THR_RST  = 8'h80,
  parameter int          CNT_W    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  input  logic                in_is_thr,
  input  logic                clr,
  input  logic                feat_ready,
  output logic [NUM_FEAT-1:0] feat_vec,
  output logic                feat_valid,
  output logic [CNT_W-1:0]    fill_cnt,
  output logic [7:0]          thr,
  output logic                overrun
);

  localparam logic [0:0]       S_COLLECT = 1'b0;
  localparam logic [0:0]       S_HOLD    = 1'b1;
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(NUM_FEAT - 1);

  logic [0:0]          r_state;
  logic [NUM_FEAT-1:0] r_acc;    // vector under construction
  logic [NUM_FEAT-1:0] r_vec;    // completed vector offered to the core
  logic                r_valid;
  logic [CNT_W-1:0]    r_cnt;
  logic [7:0]          r_thr;
  logic                r_ovr;

  logic                w_feat;
  logic                w_take;
  logic                w_bit;
  logic [NUM_FEAT-1:0] w_mask;
  logic [NUM_FEAT-1:0] w_acc_nxt;
  logic [NUM_FEAT-1:0] w_first;

  assign w_feat    = in_valid & ~in_is_thr;
  // clr on the same edge as a feature strobe discards the byte
  assign w_take    = w_feat & ~clr;
  assign w_bit     = (in_data >= r_thr);
  assign w_mask    = {{(NUM_FEAT-1){1'b0}}, 1'b1} << r_cnt;
  assign w_acc_nxt = r_acc | (w_bit ? w_mask : '0);
  assign w_first   = {{(NUM_FEAT-1){1'b0}}, w_bit};

  // While a vector is held the output shows it; otherwise it shows the
  // partial accumulation, so a zero-bubble byte only appears after valid drops.
  assign feat_vec   = r_valid ? r_vec : r_acc;
  assign feat_valid = r_valid;
  assign fill_cnt   = r_cnt;
  assign thr        = r_thr;
  assign overrun    = r_ovr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_COLLECT;
      r_acc   <= '0;
      r_vec   <= '0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
      r_thr   <= THR_RST;
      r_ovr   <= 1'b0;
    end else begin
      if (in_valid && in_is_thr) begin
        r_thr <= in_data;
      end

      case (r_state)
        S_COLLECT: begin
          if (w_take) begin
            if (r_cnt == LAST_IDX) begin
              r_vec   <= w_acc_nxt;
              r_acc   <= '0;
              r_cnt   <= '0;
              r_valid <= 1'b1;
              r_state <= S_HOLD;
            end else begin
              r_acc <= w_acc_nxt;
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          if (feat_ready) begin
            r_valid <= 1'b0;
            r_state <= S_COLLECT;
            // zero-bubble: byte on the handshake edge starts the next vector
            if (w_take) begin
              r_acc <= w_first;
              r_cnt <= CNT_W'(1);
            end
          end else if (w_take) begin
            r_ovr <= 1'b1;
          end
        end
      endcase

      // Soft clear only touches the partial vector; a held vector survives.
      if (clr) begin
        r_acc <= '0;
        r_cnt <= '0;
        r_ovr <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bnn_feature_loader.sv
module tb_bnn_feature_loader;

  localparam int NF = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_is_thr = 1'b0;
  logic        clr = 1'b0;
  logic        feat_ready = 1'b0;
  logic [7:0]  feat_vec;
  logic        feat_valid;
  logic [3:0]  fill_cnt;
  logic [7:0]  thr;
  logic        overrun;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // behavioural model: list of received bits folded into an integer
  int m_acc  = 0;
  int m_n    = 0;
  int m_held = 0;
  bit m_hold = 0;
  int m_thr  = 8'h80;
  bit m_ovr  = 0;

  bnn_feature_loader #(.NUM_FEAT(NF), .THR_RST(8'h80), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_is_thr(in_is_thr), .clr(clr), .feat_ready(feat_ready),
    .feat_vec(feat_vec), .feat_valid(feat_valid), .fill_cnt(fill_cnt),
    .thr(thr), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // model update from the inputs seen on each rising edge
  always @(posedge clk) begin
    int b;
    bit feat;
    if (!rst_n) begin
      m_acc = 0; m_n = 0; m_held = 0; m_hold = 0; m_thr = 8'h80; m_ovr = 0;
    end else begin
      feat = in_valid && !in_is_thr && !clr;
      b = (int'(in_data) >= m_thr) ? 1 : 0;
      if (m_hold) begin
        if (feat_ready) begin
          m_hold = 0;
          if (feat) begin m_acc = b; m_n = 1; end
        end else if (feat) begin
          m_ovr = 1;
        end
      end else if (feat) begin
        m_acc = m_acc + (b << m_n);
        m_n++;
        if (m_n == NF) begin
          m_held = m_acc; m_hold = 1; m_acc = 0; m_n = 0;
        end
      end
      if (clr) begin m_acc = 0; m_n = 0; m_ovr = 0; end
      if (in_valid && in_is_thr) m_thr = in_data;
    end
  end

  // compare process: outputs are stable at the falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_feat_vec",   feat_vec,   m_hold ? m_held : m_acc);
      chk("m_feat_valid", feat_valid, m_hold);
      chk("m_fill_cnt",   fill_cnt,   m_n);
      chk("m_thr",        thr,        m_thr);
      chk("m_overrun",    overrun,    m_ovr);
    end
  end

  // apply inputs for one edge; returns just after the following falling edge
  task automatic tick(input logic v, input logic t, input logic [7:0] d,
                      input logic c, input logic r);
    in_valid = v; in_is_thr = t; in_data = d; clr = c; feat_ready = r;
    @(negedge clk);
  endtask

  task automatic feed(input logic [7:0] d, input logic r);
    tick(1'b1, 1'b0, d, 1'b0, r);
  endtask

  task automatic idle(input logic r);
    tick(1'b0, 1'b0, 8'h00, 1'b0, r);
  endtask

  logic [7:0] t1 [8] = '{8'h00, 8'h80, 8'h7F, 8'hFF, 8'h81, 8'h10, 8'hC0, 8'h80};

  initial begin
    int pulses;
    @(negedge clk);
    rst_n = 1'b0;
    idle(1'b0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    chk("rst_vec", feat_vec, 0);
    chk("rst_valid", feat_valid, 0);
    chk("rst_fill", fill_cnt, 0);
    chk("rst_thr", thr, 8'h80);
    chk("rst_ovr", overrun, 0);

    // 1: basic vector
    for (int i = 0; i < 8; i++) feed(t1[i], 1'b1);
    chk("t1_valid", feat_valid, 1);
    chk("t1_vec", feat_vec, 8'hDA);
    chk("t1_fill", fill_cnt, 0);
    idle(1'b1);
    chk("t1_valid_drop", feat_valid, 0);

    // 2: threshold change mid-vector
    for (int i = 0; i < 3; i++) feed(8'h50, 1'b0);
    tick(1'b1, 1'b1, 8'h40, 1'b0, 1'b0);
    chk("t2_fill_kept", fill_cnt, 3);
    for (int i = 0; i < 5; i++) feed(8'h40, 1'b0);
    chk("t2_vec", feat_vec, 8'hF8);
    chk("t2_thr", thr, 8'h40);
    idle(1'b1);

    // 3: overrun while held
    for (int i = 0; i < 8; i++) feed(8'hFF, 1'b0);
    feed(8'h00, 1'b0);
    chk("t3_ovr", overrun, 1);
    chk("t3_vec", feat_vec, 8'hFF);
    chk("t3_valid", feat_valid, 1);
    idle(1'b1);
    chk("t3_valid_drop", feat_valid, 0);
    chk("t3_fill", fill_cnt, 0);
    tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("t3_ovr_clr", overrun, 0);

    // 4: zero-bubble handshake
    for (int i = 0; i < 8; i++) feed(8'h00, 1'b0);
    feed(8'hFF, 1'b1);
    chk("t4_valid", feat_valid, 0);
    chk("t4_fill", fill_cnt, 1);
    chk("t4_ovr", overrun, 0);
    for (int i = 0; i < 7; i++) feed(8'h00, 1'b0);
    chk("t4_vec", feat_vec, 8'h01);
    chk("t4_valid2", feat_valid, 1);
    idle(1'b1);

    // 5: clr with simultaneous byte
    for (int i = 0; i < 5; i++) feed(8'hFF, 1'b0);
    tick(1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);
    chk("t5_fill", fill_cnt, 0);
    chk("t5_vec", feat_vec, 0);
    for (int i = 0; i < 8; i++) feed(8'h90, 1'b0);
    chk("t5_vec_full", feat_vec, 8'hFF);
    idle(1'b1);

    // 6: reset mid-vector
    for (int i = 0; i < 4; i++) feed(8'hFF, 1'b1);
    rst_n = 1'b0;
    idle(1'b1);
    rst_n = 1'b1;
    chk("t6_fill", fill_cnt, 0);
    chk("t6_thr", thr, 8'h80);
    chk("t6_vec", feat_vec, 0);
    chk("t6_valid", feat_valid, 0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      feed(8'h00, 1'b1);
      if (feat_valid) pulses++;
    end
    chk("t6_vec_full", feat_vec, 0);
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      if (feat_valid) pulses++;
    end
    chk("t6_pulses", pulses, 1);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
           8'($urandom), $urandom_range(0, 29) == 0, $urandom_range(0, 2) != 0);
    end
    rst_n = 1'b1;
    idle(1'b0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
